// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with an IF/ID pipeline register.
// Holds the PC, presents it to instruction memory and captures the returned
// word into IF/ID one cycle later. Handles stalls, flushes (bubbles) and
// branch redirects, and counts the instructions loaded valid into IF/ID.
//
// Ports:
//   clk_i            clock, all state updates on the rising edge
//   rst_ni           synchronous active-low reset
//   stall_i          hold PC and IF/ID
//   flush_i          replace IF/ID with a bubble
//   branch_taken_i   redirect PC to branch_target_i (word-aligned)
//   branch_target_i  redirect target byte address
//   i_adress_o       fetch address to instruction memory (the PC register)
//   i_read_i         instruction word returned combinationally for i_adress_o
//   pc_o             PC of the instruction held in IF/ID
//   pc_plus4_o       pc_o + 4
//   inst_o           instruction held in IF/ID
//   valid_o          IF/ID holds a real instruction
//   misalign_o       one-cycle pulse: last redirect target was not word-aligned
//   fetch_count_o    number of instructions loaded valid into IF/ID
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] i_adress_o,
    input  logic [31:0] i_read_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] inst_o,
    output logic        valid_o,
    output logic        misalign_o,
    output logic [31:0] fetch_count_o
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
    localparam logic [XLEN-1:0] RESET_ALN = {RESET_PC[XLEN-1:2], 2'b00};

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic [XLEN-1:0] id_pc4_q, id_pc4_d;
    logic [XLEN-1:0] id_inst_q, id_inst_d;
    logic            id_valid_q, id_valid_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] count_q, count_d;
    logic [XLEN-1:0] pc_inc;

    assign pc_inc = pc_q + PC_STEP;

    // Next-state selection: branch > flush > stall > normal advance.
    always_comb begin
        pc_d       = pc_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        misalign_d = 1'b0;
        count_d    = count_q;

        if (branch_taken_i) begin
            pc_d       = {branch_target_i[XLEN-1:2], 2'b00};
            id_pc_d    = '0;
            id_pc4_d   = PC_STEP;
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
            misalign_d = (branch_target_i[1:0] != 2'b00);
        end else if (flush_i) begin
            // A flush under stall still bubbles IF/ID but keeps the PC.
            if (!stall_i) begin
                pc_d = pc_inc;
            end
            id_pc_d    = '0;
            id_pc4_d   = PC_STEP;
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
        end else if (!stall_i) begin
            pc_d       = pc_inc;
            id_pc_d    = pc_q;
            id_pc4_d   = pc_inc;
            id_inst_d  = i_read_i;
            id_valid_d = 1'b1;
            count_d    = count_q + XLEN'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q       <= RESET_ALN;
            id_pc_q    <= '0;
            id_pc4_q   <= PC_STEP;
            id_inst_q  <= NOP_INST;
            id_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
            misalign_q <= misalign_d;
            count_q    <= count_d;
        end
    end

    assign i_adress_o    = pc_q;
    assign pc_o          = id_pc_q;
    assign pc_plus4_o    = id_pc4_q;
    assign inst_o        = id_inst_q;
    assign valid_o       = id_valid_q;
    assign misalign_o    = misalign_q;
    assign fetch_count_o = count_q;

endmodule
